// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI receive decoder slice.
// Contents: FSM state type, default WIDTH/SYNC/IDLE_LEN values, and the
// ones-run length after which a stuff bit follows (used only when the
// NRZI_UNSTUFF_EN macro is defined).
package nrzi_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEF    = 8;
    localparam logic [7:0]  SYNC_DEF     = 8'h80;
    localparam int unsigned IDLE_LEN_DEF = 16;
    localparam int unsigned STUFF_RUN    = 6;

endpackage

// File: rtl/nrzi_rx_decoder_if.sv
// Word delivery interface of the NRZI receive decoder.
// Ports/signals:
//   data  - holding-register word (decoder -> consumer)
//   valid - holding register full (decoder -> consumer)
//   ready - consumer accepts data on an edge where valid && ready
// Modports: master (decoder side), slave (consumer side).
interface nrzi_rx_decoder_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/nrzi_bit_decoder.sv
// Line-level to bit recovery for a toggle-on-0 NRZI line.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset (previous level resets high)
//   bit_en  - sample strobe; the line is only looked at when this is 1
//   line    - encoded line level
//   b       - decoded bit: 1 when the line held, 0 when it toggled
//   b_valid - b is meaningful this cycle
module nrzi_bit_decoder (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_en,
    input  logic line,
    output logic b,
    output logic b_valid
);

    logic r_prev_line;

    // Line idles high, so resetting to 1 means a quiet line decodes as 1s.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_line <= 1'b1;
        end else if (bit_en) begin
            r_prev_line <= line;
        end
    end

    assign b       = ~(line ^ r_prev_line);
    assign b_valid = bit_en;

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: recovers bits from a toggle-on-0 line, hunts for an
// LSB-first sync word, assembles LSB-first WIDTH-bit words into a holding
// register with valid/ready delivery, and reports end of packet.
// Optional feature macro: NRZI_UNSTUFF_EN (bit unstuffing after a run of
// STUFF_RUN ones; replaces the IDLE_LEN end-of-packet rule).
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bit_en, line - sample strobe and encoded line level
//   rx           - word delivery interface (data/valid out, ready in)
//   sync_det     - 1-cycle pulse when the sync word is found
//   eop          - 1-cycle pulse on end of packet
//   overflow     - 1-cycle pulse when a completed word is dropped
//   stuff_err    - 1-cycle pulse on a stuffing violation (0 without macro)
module nrzi_rx_decoder
    import nrzi_pkg::*;
#(
    parameter int unsigned      WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SYNC     = WIDTH'(SYNC_DEF),
    parameter int unsigned      IDLE_LEN = IDLE_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               bit_en,
    input  logic               line,
    nrzi_rx_decoder_if.master  rx,
    output logic               sync_det,
    output logic               eop,
    output logic               overflow,
    output logic               stuff_err
);

    localparam int unsigned BC_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned HC_W  = $clog2(WIDTH + 1);
    localparam int unsigned RUN_W = $clog2(IDLE_LEN + 1);

    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [HC_W-1:0]  HC_FULL = HC_W'(WIDTH);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(IDLE_LEN);
`ifdef NRZI_UNSTUFF_EN
    localparam logic [RUN_W-1:0] STUFF_LIM = RUN_W'(STUFF_RUN);
`endif

    logic w_b;
    logic w_b_valid;

    nrzi_bit_decoder u_bit_dec (
        .clk     (clk),
        .reset_n (reset_n),
        .bit_en  (bit_en),
        .line    (line),
        .b       (w_b),
        .b_valid (w_b_valid)
    );

    state_t           r_state,    w_state_nx;
    logic [WIDTH-1:0] r_sr,       w_sr_nx;
    logic [BC_W-1:0]  r_bitcnt,   w_bitcnt_nx;
    logic [HC_W-1:0]  r_hcnt,     w_hcnt_nx;
    logic [RUN_W-1:0] r_run,      w_run_nx;
    logic [WIDTH-1:0] r_data,     w_data_nx;
    logic             r_valid,    w_valid_nx;
    logic             r_sync_det, w_sync_det_nx;
    logic             r_eop,      w_eop_nx;
    logic             r_overflow, w_overflow_nx;
`ifdef NRZI_UNSTUFF_EN
    logic             r_stuff_err, w_stuff_err_nx;
`endif

    logic [WIDTH-1:0] w_shift;
    logic             w_take;
    logic             w_complete;

    assign w_shift = {w_b, r_sr[WIDTH-1:1]};

    always_comb begin
        w_state_nx    = r_state;
        w_sr_nx       = r_sr;
        w_bitcnt_nx   = r_bitcnt;
        w_hcnt_nx     = r_hcnt;
        w_run_nx      = r_run;
        w_data_nx     = r_data;
        w_valid_nx    = r_valid;
        w_sync_det_nx = 1'b0;
        w_eop_nx      = 1'b0;
        w_overflow_nx = 1'b0;
`ifdef NRZI_UNSTUFF_EN
        w_stuff_err_nx = 1'b0;
`endif
        w_take        = 1'b0;
        w_complete    = 1'b0;

        if (w_b_valid) begin
            // Ones-run tracks every decoded bit regardless of state.
            if (!w_b) begin
                w_run_nx = '0;
            end else if (r_run != RUN_MAX) begin
                w_run_nx = r_run + 1'b1;
            end

            case (r_state)
                HUNT: begin
                    w_sr_nx = w_shift;
                    if (r_hcnt != HC_FULL) begin
                        w_hcnt_nx = r_hcnt + 1'b1;
                    end
                    // Require a full window of fresh bits so reset-time
                    // register contents can never fake a sync match.
                    if (w_shift == SYNC && w_hcnt_nx == HC_FULL) begin
                        w_sync_det_nx = 1'b1;
                        w_state_nx    = DATA;
                        w_bitcnt_nx   = '0;
                        w_run_nx      = '0;
                    end
                end
                DATA: begin
`ifdef NRZI_UNSTUFF_EN
                    if (r_run == STUFF_LIM) begin
                        // This bit is the stuff slot: a 0 is dropped (run
                        // already cleared above); a 1 ends the packet.
                        if (w_b) begin
                            w_state_nx  = HUNT;
                            w_hcnt_nx   = '0;
                            w_bitcnt_nx = '0;
                            if (r_bitcnt == '0) begin
                                w_eop_nx = 1'b1;
                            end else begin
                                w_stuff_err_nx = 1'b1;
                            end
                        end
                    end else begin
                        w_take = 1'b1;
                    end
`else
                    // EOP wins over a word completing on the same bit.
                    if (w_run_nx == RUN_MAX) begin
                        w_eop_nx    = 1'b1;
                        w_state_nx  = HUNT;
                        w_hcnt_nx   = '0;
                        w_bitcnt_nx = '0;
                    end else begin
                        w_take = 1'b1;
                    end
`endif
                    if (w_take) begin
                        w_sr_nx = w_shift;
                        if (r_bitcnt == BC_LAST) begin
                            w_complete  = 1'b1;
                            w_bitcnt_nx = '0;
                        end else begin
                            w_bitcnt_nx = r_bitcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nx = HUNT;
                end
            endcase
        end

        // Accept first, then let a same-edge completion refill the register.
        if (r_valid && rx.ready) begin
            w_valid_nx = 1'b0;
        end
        if (w_complete) begin
            if (r_valid && !rx.ready) begin
                w_overflow_nx = 1'b1;
            end else begin
                w_data_nx  = w_shift;
                w_valid_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HUNT;
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_hcnt      <= '0;
            r_run       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sync_det  <= 1'b0;
            r_eop       <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef NRZI_UNSTUFF_EN
            r_stuff_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_sr        <= w_sr_nx;
            r_bitcnt    <= w_bitcnt_nx;
            r_hcnt      <= w_hcnt_nx;
            r_run       <= w_run_nx;
            r_data      <= w_data_nx;
            r_valid     <= w_valid_nx;
            r_sync_det  <= w_sync_det_nx;
            r_eop       <= w_eop_nx;
            r_overflow  <= w_overflow_nx;
`ifdef NRZI_UNSTUFF_EN
            r_stuff_err <= w_stuff_err_nx;
`endif
        end
    end

    assign rx.data  = r_data;
    assign rx.valid = r_valid;
    assign sync_det = r_sync_det;
    assign eop      = r_eop;
    assign overflow = r_overflow;
`ifdef NRZI_UNSTUFF_EN
    assign stuff_err = r_stuff_err;
`else
    assign stuff_err = 1'b0;
`endif

endmodule
